// File: rtl/dequant_pkg.sv
// Shared binary32 field geometry, default step sizes and pipeline depth for the dequantizer.
package dequant_pkg;

   localparam int SIGN_W     = 1;
   localparam int EXP_W      = 8;
   localparam int MANT_W     = 23;
   localparam int EXP_BIAS   = 127;
   localparam int PIPE_DEPTH = 5;

   localparam logic [31:0] DEF_WEIGHT_STEP = 32'h3C00_0000;  // 2^-7
   localparam logic [31:0] DEF_ACT_STEP    = 32'h3D80_0000;  // 2^-4

   typedef struct packed {
      logic [SIGN_W-1:0] sign;
      logic [EXP_W-1:0]  exp;
      logic [MANT_W-1:0] mant;
   } fp32_t;

   // Leading-zero count of a 32-bit word; 0 is returned for v == 0 (callers flag zero separately).
   function automatic logic [4:0] lzc32(input logic [31:0] v);
      logic [4:0] n;
      n = 5'd0;
      for (int i = 0; i < 32; i++)
         if (v[i]) n = 5'(31 - i);
      return n;
   endfunction

endpackage

// File: rtl/fp32_mul_pipe.sv
// Three-stage binary32 multiply: RNE rounding, flush-to-zero, overflow to Inf
// (or to max finite when DEQUANT_SATURATE_EN is defined). Output register is the last stage.
module fp32_mul_pipe
   import dequant_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  fp32_t       a_i,
   input  fp32_t       b_i,
   output logic [31:0] y_o
);

   logic               s3_sign_q, s3_zero_q;
   logic signed [9:0]  s3_exp_q;
   logic [47:0]        s3_prod_q;
   logic               s4_sign_q, s4_zero_q;
   logic signed [9:0]  s4_exp_q;
   logic [22:0]        s4_mant_q;
   logic [31:0]        y_q;

   logic               s3_sign_d, s3_zero_d;
   logic signed [9:0]  s3_exp_d, s4_exp_d;
   logic [47:0]        s3_prod_d;
   logic [22:0]        mant_tr;
   logic               guard, sticky;
   logic [23:0]        mant_rnd;
   logic [31:0]        y_d, ovf;

   always_comb begin
      // A zero multiplicand is an exact integer 0 and always gives +0; a zero/subnormal
      // multiplier keeps the XOR sign.
      s3_zero_d = (a_i.exp == '0) || (b_i.exp == '0);
      s3_sign_d = (a_i.sign ^ b_i.sign) & (a_i.exp != '0);
      s3_exp_d  = $signed({2'b00, a_i.exp}) + $signed({2'b00, b_i.exp}) - 10'sd127;
      s3_prod_d = 48'({1'b1, a_i.mant}) * 48'({1'b1, b_i.mant});
   end

   always_comb begin
      if (s3_prod_q[47]) begin
         mant_tr  = s3_prod_q[46:24];
         guard    = s3_prod_q[23];
         sticky   = |s3_prod_q[22:0];
         s4_exp_d = s3_exp_q + 10'sd1;
      end else begin
         mant_tr  = s3_prod_q[45:23];
         guard    = s3_prod_q[22];
         sticky   = |s3_prod_q[21:0];
         s4_exp_d = s3_exp_q;
      end
      mant_rnd = {1'b0, mant_tr} + 24'(guard & (sticky | mant_tr[0]));
      if (mant_rnd[23]) s4_exp_d = s4_exp_d + 10'sd1;
   end

   always_comb begin
`ifdef DEQUANT_SATURATE_EN
      ovf = {s4_sign_q, 8'hFE, 23'h7F_FFFF};
`else
      ovf = {s4_sign_q, 8'hFF, 23'h0};
`endif
      if (s4_zero_q || s4_exp_q <= 10'sd0)
         y_d = {s4_sign_q, 31'd0};
      else if (s4_exp_q >= 10'sd255)
         y_d = ovf;
      else
         y_d = {s4_sign_q, s4_exp_q[7:0], s4_mant_q};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s3_sign_q <= 1'b0;
         s3_zero_q <= 1'b1;
         s3_exp_q  <= '0;
         s3_prod_q <= '0;
         s4_sign_q <= 1'b0;
         s4_zero_q <= 1'b1;
         s4_exp_q  <= '0;
         s4_mant_q <= '0;
         y_q       <= '0;
      end else begin
         s3_sign_q <= s3_sign_d;
         s3_zero_q <= s3_zero_d;
         s3_exp_q  <= s3_exp_d;
         s3_prod_q <= s3_prod_d;
         s4_sign_q <= s3_sign_q;
         s4_zero_q <= s3_zero_q;
         s4_exp_q  <= s4_exp_d;
         s4_mant_q <= mant_rnd[22:0];
         y_q       <= y_d;
      end
   end

   assign y_o = y_q;

endmodule

// File: rtl/dequantizer_block.sv
// Dequantizer: int32 level -> binary32 (RNE) -> times selected step (RNE), five register stages.
// Overflow saturates instead of going to Inf when DEQUANT_SATURATE_EN is defined.
module dequantizer_block
   import dequant_pkg::*;
#(
   parameter logic [31:0] WEIGHT_STEP = DEF_WEIGHT_STEP,
   parameter logic [31:0] ACT_STEP    = DEF_ACT_STEP
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] level_int,
   input  logic        is_weight,
   output logic [31:0] weight_fp_reg
);

   logic [31:0] level_q, step_q;
   fp32_t       a_q, b_q;

   logic [31:0] mag;
   logic [4:0]  lz;
   logic [30:0] norm;
   logic [23:0] mant_rnd;
   fp32_t       a_d;

   always_comb begin
      mag      = level_q[31] ? (~level_q + 32'd1) : level_q;
      lz       = lzc32(mag);
      // Bit 31 of the shifted magnitude is the implicit one and is dropped.
      norm     = 31'(mag << lz);
      mant_rnd = {1'b0, norm[30:8]} + 24'(norm[7] & (norm[8] | (|norm[6:0])));
      a_d      = '0;
      if (mag != 32'd0) begin
         a_d.sign = level_q[31];
         a_d.exp  = 8'(EXP_BIAS + 31 - int'(lz)) + {7'd0, mant_rnd[23]};
         a_d.mant = mant_rnd[22:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         level_q <= '0;
         step_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         level_q <= level_int;
         step_q  <= is_weight ? WEIGHT_STEP : ACT_STEP;
         a_q     <= a_d;
         b_q     <= step_q;
      end
   end

   fp32_mul_pipe u_mul (
      .clk (clk),
      .rst (rst),
      .a_i (a_q),
      .b_i (b_q),
      .y_o (weight_fp_reg)
   );

endmodule

// File: tb/tb_dequantizer_block.sv
// Directed bench for dequantizer_block: default-step instance plus an overflow/zero-step instance.
module tb_dequantizer_block;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] level_int = '0;
   logic        is_weight = 1'b0;
   logic [31:0] y1, y2;
   int          tests = 0;
   int          fails = 0;

`ifdef DEQUANT_SATURATE_EN
   localparam logic [31:0] OVF_P = 32'h7F7F_FFFF;
   localparam logic [31:0] OVF_N = 32'hFF7F_FFFF;
`else
   localparam logic [31:0] OVF_P = 32'h7F80_0000;
   localparam logic [31:0] OVF_N = 32'hFF80_0000;
`endif

   always #5 clk = ~clk;

   dequantizer_block dut1 (
      .clk(clk), .rst(rst), .level_int(level_int), .is_weight(is_weight), .weight_fp_reg(y1)
   );

   // Huge weight step for overflow; negative subnormal activation step (treated as -0).
   dequantizer_block #(.WEIGHT_STEP(32'h7F00_0000), .ACT_STEP(32'h8040_0000)) dut2 (
      .clk(clk), .rst(rst), .level_int(level_int), .is_weight(is_weight), .weight_fp_reg(y2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] l, input logic w);
      @(negedge clk);
      level_int = l;
      is_weight = w;
   endtask

   // One isolated vector: result after sampling edge N+4, zero again one cycle later.
   task automatic run1(input string tag, input logic [31:0] l, input logic w,
                       input logic [31:0] e1, input logic [31:0] e2);
      drive(l, w);
      drive(32'd0, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      chk({tag, "_d1"}, y1, e1);
      chk({tag, "_d2"}, y2, e2);
      @(posedge clk);
      #1;
      chk({tag, "_hold1"}, y1, 32'h0);
   endtask

   logic [31:0] stream_exp [5] = '{32'h3D80_0000, 32'h3E00_0000, 32'h3E40_0000,
                                   32'h3E80_0000, 32'h3EA0_0000};

   initial begin
      #1;
      chk("reset_d1", y1, 32'h0);
      chk("reset_d2", y2, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      run1("zero_w",    32'd0,          1'b1, 32'h0000_0000, 32'h0000_0000);
      run1("one_w",     32'd1,          1'b1, 32'h3C00_0000, 32'h7F00_0000);
      run1("m3_a",      -32'sd3,        1'b0, 32'hBE40_0000, 32'h0000_0000);
      run1("big_rnd",   32'd16777217,   1'b0, 32'h4980_0000, 32'h8000_0000);
      run1("tie_up",    32'd16777219,   1'b0, 32'h4980_0002, 32'h8000_0000);
      run1("exact_2p24",32'd16777218,   1'b0, 32'h4980_0001, 32'h8000_0000);
      run1("min_int",   32'h8000_0000,  1'b1, 32'hCB80_0000, OVF_N);
      run1("max_int",   32'h7FFF_FFFF,  1'b1, 32'h4B80_0000, OVF_P);
      run1("ovf_pos",   32'd4,          1'b1, 32'h3D00_0000, OVF_P);
      run1("ovf_neg",   -32'sd4,        1'b1, 32'hBD00_0000, OVF_N);
      run1("zero_negstep", 32'd0,       1'b0, 32'h0000_0000, 32'h0000_0000);
      run1("ftz_step",  32'd5,          1'b0, 32'h3EA0_0000, 32'h8000_0000);

      // Back-to-back stream 1..5
      for (int k = 1; k <= 5; k++) drive(32'(k), 1'b0);
      @(posedge clk);
      #1;
      chk("stream_0", y1, stream_exp[0]);
      for (int k = 1; k < 5; k++) begin
         drive(32'd0, 1'b0);
         @(posedge clk);
         #1;
         chk($sformatf("stream_%0d", k), y1, stream_exp[k]);
      end

      // Reset in the middle of a stream
      for (int k = 6; k <= 10; k++) drive(32'(k), 1'b0);
      @(posedge clk);
      #1;
      chk("pre_rst", y1, 32'h3EC0_0000);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_async_d1", y1, 32'h0);
      chk("rst_async_d2", y2, 32'h0);
      @(posedge clk);
      #1;
      chk("rst_held", y1, 32'h0);
      @(negedge clk);
      rst       = 1'b1;
      level_int = 32'd11;
      is_weight = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("post_rst_empty_%0d", k), y1, 32'h0);
         if (k == 0) begin
            @(negedge clk);
            level_int = 32'd12;
         end
      end
      @(posedge clk);
      #1;
      chk("post_rst_first", y1, 32'h3F30_0000);
      @(posedge clk);
      #1;
      chk("post_rst_second", y1, 32'h3F40_0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dequantizer_block.md
DEQUANTIZER_BLOCK -- requirements
Module: dequantizer_block

Interface
REQ-001 Parameter WEIGHT_STEP, default 32'h3C000000 (2^-7), SHALL give the IEEE-754 binary32 step size applied when is_weight=1.
REQ-002 Parameter ACT_STEP, default 32'h3D800000 (2^-4), SHALL give the binary32 step size applied when is_weight=0.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 level_int  input  32  SHALL carry the quantization level as a two's-complement signed integer.
REQ-006 is_weight  input  1  SHALL select the step: 1 = WEIGHT_STEP, 0 = ACT_STEP.
REQ-007 weight_fp_reg  output  32  SHALL carry the registered binary32 dequantized value.

Function
REQ-008 Result SHALL equal fp32(fp32(level_int) x step), where step is selected by is_weight.
REQ-009 Integer-to-float conversion SHALL round to nearest, ties to even, because levels above 2^24 in magnitude are not exact.
REQ-010 Multiplication SHALL apply a second, independent round to nearest, ties to even.
REQ-011 level_int=0 SHALL yield +0.0 (32'h00000000) regardless of step.
REQ-012 Sign SHALL be sign(level_int) XOR sign(step); level -2^31 SHALL convert exactly to -2^31.
REQ-013 Subnormal products SHALL flush to signed zero; subnormal step parameters SHALL be treated as zero.
REQ-014 Without the configuration macro, exponent overflow SHALL yield signed infinity (7F800000/FF800000).
REQ-015 Step parameters that are NaN or Inf are unsupported; behaviour for them is unspecified.
REQ-016 Datapath SHALL be fully pipelined: a new input is accepted every cycle, with no handshake and no stall.
REQ-017 Inputs sampled at rising edge N SHALL appear on weight_fp_reg after rising edge N+4 (five register stages, the output register being the last) and hold for one cycle.
REQ-018 Consecutive inputs SHALL emerge in order, one per cycle, with no bubbles or reuse.

Reset
REQ-019 rst=0 SHALL immediately clear every pipeline register and force weight_fp_reg to 32'h00000000, independent of clk.
REQ-020 Reset asserted mid-stream SHALL discard all in-flight results.
REQ-021 After rst deasserts, the output SHALL remain 0 until the first post-reset input reaches the output at edge N+4.

Configuration
REQ-022 Macro DEQUANT_SATURATE_EN, when defined, SHALL replace overflow results with signed max finite (7F7FFFFF/FF7FFFFF).
REQ-023 When DEQUANT_SATURATE_EN is undefined, overflow SHALL produce infinity per REQ-014.
REQ-024 DEQUANT_SATURATE_EN SHALL NOT change latency or any non-overflow result.

Structure
REQ-025 Package dequant_pkg SHALL hold fp32 field widths (sign 1, exponent 8, mantissa 23), the exponent bias 127, default step constants, and the pipeline depth constant 5.
REQ-026 The multiply SHALL be a sub-module fp32_mul_pipe (binary32 multiply with RNE, FTZ and optional saturation), instantiated once.
REQ-027 Integer-to-float conversion (leading-zero count, normalise, round) SHALL reside in dequantizer_block.

Verification
REQ-028 level=0, is_weight=1 -> 00000000 after 5 edges.
REQ-029 level=1, is_weight=1 -> 3C000000; level=-3, is_weight=0 -> BE400000.
REQ-030 level=16777217, is_weight=0 -> 49800000 (conversion rounds to 2^24, times 2^-4).
REQ-031 Back-to-back stream 1,2,3,4,5 (is_weight=0) -> 3D800000, 3E000000, 3E400000, 3E800000, 3EA00000 on consecutive cycles, each 4 edges after its sampling edge.
REQ-032 Assert rst low mid-stream -> output 00000000 immediately; then the stream resumes with the first new result at N+4.
REQ-033 WEIGHT_STEP=7F000000, level=4, is_weight=1 -> 7F800000 without DEQUANT_SATURATE_EN, 7F7FFFFF with it.
